// File: rtl/rom256x1_byte_arb_if.sv
// ============================================================================
// rom256x1_byte_arb_if : requester/ROM bundle for the byte-assembling arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface rom256x1_byte_arb_if;
  logic [3:0]  req;
  logic [19:0] ba;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  dout;
  logic        busy;
  logic [7:0]  rad;
  logic        rdi;

  modport master (
    output req, ba, rdi,
    input  gnt, ack, dout, busy, rad
  );

  modport slave (
    input  req, ba, rdi,
    output gnt, ack, dout, busy, rad
  );
endinterface

`default_nettype wire

// File: rtl/rom256x1_byte_arb.sv
// ============================================================================
// rom256x1_byte_arb : 4-way round-robin arbiter fetching bytes from a 256x1 ROM
// Revision: 1.0
// ============================================================================
`default_nettype none

module rom256x1_byte_arb #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  wire logic          clk_i,
  input  wire logic          rst_ni,
  rom256x1_byte_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     state_q;
  logic [2:0] k_q;
  logic [4:0] ba_q;
  logic [1:0] win_q;
  logic [1:0] last_q;
  logic [7:0] sh_q;
  logic [7:0] dout_q;
  logic [7:0] rad_q;
  logic [3:0] gnt_q;
  logic [3:0] ack_q;
  logic       busy_q;

  logic [1:0] pick_d;
  logic [4:0] ba_sel_d;
  logic [2:0] bit_idx_d;
  logic [7:0] byte_d;

  // Scan from the farthest candidate back to the nearest so the nearest
  // requester after the last winner is the one left in pick_d.
  always_comb begin
    logic [1:0] idx;
    pick_d = last_q;
    for (int i = 3; i >= 0; i--) begin
      idx = last_q + 2'(i + 1);
      if (bus.req[idx]) pick_d = idx;
    end
  end

  always_comb begin
    ba_sel_d  = bus.ba[pick_d*5 +: 5];
    bit_idx_d = MSB_FIRST ? (3'd7 - k_q) : k_q;
    byte_d    = sh_q;
    byte_d[bit_idx_d] = bus.rdi;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      k_q     <= 3'd0;
      ba_q    <= 5'd0;
      win_q   <= 2'd0;
      last_q  <= 2'd3;
      sh_q    <= 8'h00;
      dout_q  <= 8'h00;
      rad_q   <= 8'h00;
      gnt_q   <= 4'b0000;
      ack_q   <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= 4'b0000;
          rad_q <= 8'h00;
          gnt_q <= 4'b0000;
          if (|bus.req) begin
            win_q   <= pick_d;
            ba_q    <= ba_sel_d;
            gnt_q   <= 4'b0001 << pick_d;
            k_q     <= 3'd0;
            sh_q    <= 8'h00;
            rad_q   <= {ba_sel_d, 3'd0};
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          sh_q <= byte_d;
          k_q  <= k_q + 3'd1;
          if (k_q == 3'd7) begin
            dout_q  <= byte_d;
            gnt_q   <= 4'b0000;
            ack_q   <= 4'b0001 << win_q;
            rad_q   <= 8'h00;
            state_q <= S_DONE;
          end else begin
            rad_q <= {ba_q, k_q + 3'd1};
          end
        end
        S_DONE: begin
          ack_q   <= 4'b0000;
          last_q  <= win_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.ack  = ack_q;
  assign bus.dout = dout_q;
  assign bus.busy = busy_q;
  assign bus.rad  = rad_q;

endmodule

`default_nettype wire
